// File: rtl/bitcoin_hash_pkg.sv
// Shared SHA-256 constants, FSM state type and round helper functions.
// Latency: n/a (combinational helpers and constants only).
// Backpressure: n/a.
package bitcoin_hash_pkg;

    localparam logic [0:63][31:0] K = {
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    localparam logic [0:7][31:0] IV = {
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    // Padding marker and message bit lengths: block 2 closes an 80-byte
    // header, block 3 hashes a 32-byte digest.
    localparam logic [31:0] PAD_WORD = 32'h80000000;
    localparam logic [31:0] LEN_BLK2 = 32'd640;
    localparam logic [31:0] LEN_BLK3 = 32'd256;

    typedef enum logic [3:0] {
        IDLE, MID_SET, MID_RND, MID_UPD,
        B2_SET, B2_RND, B2_UPD,
        B3_SET, B3_RND, B3_UPD,
        DRAIN, FIN
    } state_t;

    function automatic logic [31:0] rightrotate(input logic [31:0] x, input logic [4:0] n);
        return (x >> n) | (x << (6'd32 - {1'b0, n}));
    endfunction

    function automatic logic [31:0] small_sigma0(input logic [31:0] x);
        return rightrotate(x, 5'd7) ^ rightrotate(x, 5'd18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] small_sigma1(input logic [31:0] x);
        return rightrotate(x, 5'd17) ^ rightrotate(x, 5'd19) ^ (x >> 10);
    endfunction

    function automatic logic [31:0] big_sigma0(input logic [31:0] x);
        return rightrotate(x, 5'd2) ^ rightrotate(x, 5'd13) ^ rightrotate(x, 5'd22);
    endfunction

    function automatic logic [31:0] big_sigma1(input logic [31:0] x);
        return rightrotate(x, 5'd6) ^ rightrotate(x, 5'd11) ^ rightrotate(x, 5'd25);
    endfunction

    function automatic logic [31:0] ch(input logic [31:0] e, input logic [31:0] f, input logic [31:0] g);
        return (e & f) ^ (~e & g);
    endfunction

    function automatic logic [31:0] maj(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
        return (a & b) ^ (a & c) ^ (b & c);
    endfunction

    // W[t] from W[t-2], W[t-7], W[t-15], W[t-16].
    function automatic logic [31:0] word_expand(input logic [31:0] w2, input logic [31:0] w7,
                                                input logic [31:0] w15, input logic [31:0] w16);
        return small_sigma1(w2) + w7 + small_sigma0(w15) + w16;
    endfunction

endpackage

// File: rtl/sha256_lane.sv
// One SHA-256 compression lane: A..H registers plus a 16-word rolling W window.
// Latency: 1 cycle to load, then one round per step; digest add is done by the caller.
// Backpressure: none; the lane only advances when step is asserted.
module sha256_lane
    import bitcoin_hash_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic              load,
    input  logic [0:7][31:0]  load_state,
    input  logic [0:15][31:0] load_w,
    input  logic [5:0]        t,
    input  logic              step,
    output logic [0:7][31:0]  state
);

    logic [0:15][31:0] w;
    logic [3:0]        wi;
    logic [31:0]       w_t;
    logic [31:0]       t1;
    logic [31:0]       t2;

    // Round t message word (expanded in place for t >= 16) and round temporaries.
    always_comb begin
        wi = t[3:0];
        if (t < 6'd16) begin
            w_t = w[wi];
        end else begin
            w_t = word_expand(w[wi - 4'd2], w[wi - 4'd7], w[wi - 4'd15], w[wi]);
        end
        t1 = state[7] + big_sigma1(state[4]) + ch(state[4], state[5], state[6]) + K[t] + w_t;
        t2 = big_sigma0(state[0]) + maj(state[0], state[1], state[2]);
    end

    // Load or advance one round; the new W[t] overwrites W[t-16] in the window.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= '0;
            w     <= '0;
        end else if (load) begin
            state <= load_state;
            w     <= load_w;
        end else if (step) begin
            state <= {t1 + t2, state[0], state[1], state[2], state[3] + t1, state[4], state[5], state[6]};
            w[wi] <= w_t;
        end
    end

endmodule

// File: rtl/bitcoin_hash_lanes.sv
// Multi-lane Bitcoin nonce sweep: midstate once, then batches of LANES double-SHA-256 hashes.
// Latency: 66 + (NUM_NONCES/LANES)*(132+LANES) + 1 cycles start-to-done with res_ready held high.
// Backpressure: results drain one per res_valid/res_ready handshake; stalls hold the current result.
module bitcoin_hash_lanes
    import bitcoin_hash_pkg::*;
#(
    parameter int LANES      = 8,
    parameter int NUM_NONCES = 16
)(
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [0:18][31:0] header,
    input  logic [31:0]       nonce_base,
    output logic              busy,
    output logic              done,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [31:0]       res_nonce,
    output logic [31:0]       res_h0
);

    localparam int NB = (LANES > 0) ? NUM_NONCES / LANES : 1;
    localparam int BW = (NB > 1) ? $clog2(NB) : 1;
    localparam int IW = (LANES > 1) ? $clog2(LANES) : 1;

    if (LANES < 1 || LANES > 16) begin : g_bad_lanes
        $error("bitcoin_hash_lanes: LANES must be in 1..16");
    end
    if (LANES > 0 && (NUM_NONCES < LANES || (NUM_NONCES % LANES) != 0)) begin : g_bad_nonces
        $error("bitcoin_hash_lanes: NUM_NONCES must be a non-zero multiple of LANES");
    end

    state_t            state_q;
    state_t            state_d;
    logic [5:0]        t_q;
    logic [BW-1:0]     batch_q;
    logic [IW-1:0]     drain_idx_q;
    logic [0:18][31:0] hdr_q;
    logic [31:0]       base_q;
    logic [0:7][31:0]  mid_q;
    logic [0:7][31:0]  dig2_q  [LANES];
    logic [31:0]       h0_q    [LANES];
    logic [0:7][31:0]  lane_st [LANES];

    logic        load_phase;
    logic        step_phase;
    logic        mid_phase;
    logic        last_lane;
    logic        batch_last;
    logic [31:0] batch_ofs;

    assign mid_phase  = (state_q == MID_SET) || (state_q == MID_RND) || (state_q == MID_UPD);
    assign last_lane  = (drain_idx_q == IW'(LANES - 1));
    assign batch_last = (batch_q == BW'(NB - 1));
    assign batch_ofs  = 32'(batch_q) * 32'(LANES);

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and phase strobes.
    always_comb begin
        state_d    = state_q;
        busy       = 1'b1;
        done       = 1'b0;
        res_valid  = 1'b0;
        load_phase = 1'b0;
        step_phase = 1'b0;
        case (state_q)
            IDLE: begin
                busy = 1'b0;
                if (start) state_d = MID_SET;
            end
            MID_SET: begin load_phase = 1'b1; state_d = MID_RND; end
            MID_RND: begin step_phase = 1'b1; if (t_q == 6'd63) state_d = MID_UPD; end
            MID_UPD: state_d = B2_SET;
            B2_SET:  begin load_phase = 1'b1; state_d = B2_RND; end
            B2_RND:  begin step_phase = 1'b1; if (t_q == 6'd63) state_d = B2_UPD; end
            B2_UPD:  state_d = B3_SET;
            B3_SET:  begin load_phase = 1'b1; state_d = B3_RND; end
            B3_RND:  begin step_phase = 1'b1; if (t_q == 6'd63) state_d = B3_UPD; end
            B3_UPD:  state_d = DRAIN;
            DRAIN: begin
                res_valid = 1'b1;
                if (res_ready && last_lane) state_d = batch_last ? FIN : B2_SET;
            end
            FIN: begin
                busy    = 1'b0;
                done    = 1'b1;
                state_d = IDLE;
            end
            default: begin
                busy    = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // Job latches, round/batch/drain counters and digest feed-forward adds.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            t_q         <= '0;
            batch_q     <= '0;
            drain_idx_q <= '0;
            hdr_q       <= '0;
            base_q      <= '0;
            mid_q       <= '0;
            for (int i = 0; i < LANES; i++) begin
                dig2_q[i] <= '0;
                h0_q[i]   <= '0;
            end
        end else begin
            if (state_q == IDLE && start) begin
                hdr_q       <= header;
                base_q      <= nonce_base;
                batch_q     <= '0;
                drain_idx_q <= '0;
            end
            if (load_phase) begin
                t_q <= '0;
            end else if (step_phase) begin
                t_q <= t_q + 6'd1;
            end
            if (state_q == MID_UPD) begin
                for (int j = 0; j < 8; j++) mid_q[j] <= IV[j] + lane_st[0][j];
            end
            if (state_q == B2_UPD) begin
                for (int i = 0; i < LANES; i++) begin
                    for (int j = 0; j < 8; j++) dig2_q[i][j] <= mid_q[j] + lane_st[i][j];
                end
            end
            if (state_q == B3_UPD) begin
                for (int i = 0; i < LANES; i++) h0_q[i] <= IV[0] + lane_st[i][0];
            end
            if (res_valid && res_ready) begin
                if (last_lane) begin
                    drain_idx_q <= '0;
                    if (!batch_last) batch_q <= batch_q + BW'(1);
                end else begin
                    drain_idx_q <= drain_idx_q + IW'(1);
                end
            end
        end
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        logic [0:15][31:0] ld_w;
        logic [0:7][31:0]  ld_st;
        logic [31:0]       nonce;
        logic              en;

        assign nonce = base_q + batch_ofs + 32'(i);
        // Only lane 0 runs the midstate pass; the others sit idle until block 2.
        assign en    = (i == 0) || !mid_phase;

        // Per-phase block and chaining value for this lane.
        always_comb begin
            ld_w  = '0;
            ld_st = mid_q;
            case (state_q)
                MID_SET: begin
                    ld_w  = hdr_q[0:15];
                    ld_st = IV;
                end
                B3_SET: begin
                    ld_w[0:7] = dig2_q[i];
                    ld_w[8]   = PAD_WORD;
                    ld_w[15]  = LEN_BLK3;
                    ld_st     = IV;
                end
                default: begin
                    ld_w[0:2] = hdr_q[16:18];
                    ld_w[3]   = nonce;
                    ld_w[4]   = PAD_WORD;
                    ld_w[15]  = LEN_BLK2;
                end
            endcase
        end

        sha256_lane u_lane (
            .clk        (clk),
            .reset_n    (reset_n),
            .load       (en && load_phase),
            .load_state (ld_st),
            .load_w     (ld_w),
            .t          (t_q),
            .step       (en && step_phase),
            .state      (lane_st[i])
        );
    end

    // Present the current drain lane; zero outside DRAIN.
    always_comb begin
        res_nonce = '0;
        res_h0    = '0;
        if (state_q == DRAIN) begin
            res_nonce = base_q + batch_ofs + 32'(drain_idx_q);
            for (int i = 0; i < LANES; i++) begin
                if (drain_idx_q == IW'(i)) res_h0 = h0_q[i];
            end
        end
    end

endmodule

// File: tb/tb_bitcoin_hash_lanes.sv
// Self-checking bench for bitcoin_hash_lanes against a textbook double-SHA-256 model.
// Latency: checks exact start-to-done cycle count when the consumer never stalls.
// Backpressure: exercises random res_ready and a long stall, checking result stability.
module tb_bitcoin_hash_lanes;

    localparam int LANES      = 8;
    localparam int NUM_NONCES = 16;
    localparam int JOB_LAT    = 66 + (NUM_NONCES / LANES) * (132 + LANES) + 1;
    localparam int BUDGET     = 3000;

    typedef logic [0:7][31:0]  st_t;
    typedef logic [0:15][31:0] blk_t;

    localparam logic [31:0] KT [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };
    localparam st_t IV_T = {32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                            32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};

    logic              clk = 1'b0;
    logic              reset_n;
    logic              start;
    logic [0:18][31:0] header;
    logic [31:0]       nonce_base;
    logic              busy;
    logic              done;
    logic              res_valid;
    logic              res_ready;
    logic [31:0]       res_nonce;
    logic [31:0]       res_h0;

    int errors = 0;
    int checks = 0;
    logic [31:0] exp_nonce [NUM_NONCES];
    logic [31:0] exp_h0    [NUM_NONCES];

    bitcoin_hash_lanes #(.LANES(LANES), .NUM_NONCES(NUM_NONCES)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .header     (header),
        .nonce_base (nonce_base),
        .busy       (busy),
        .done       (done),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_nonce  (res_nonce),
        .res_h0     (res_h0)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ror(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    // FIPS 180-4 compression with a full 64-entry schedule, including the feed-forward add.
    function automatic st_t compress(input st_t h, input blk_t m);
        logic [31:0] w [64];
        logic [31:0] a, b, c, d, e, f, g, hh, t1, t2, s0, s1;
        st_t r;
        for (int i = 0; i < 16; i++) w[i] = m[i];
        for (int i = 16; i < 64; i++) begin
            s0   = ror(w[i-15], 7) ^ ror(w[i-15], 18) ^ (w[i-15] >> 3);
            s1   = ror(w[i-2], 17) ^ ror(w[i-2], 19) ^ (w[i-2] >> 10);
            w[i] = w[i-16] + s0 + w[i-7] + s1;
        end
        a = h[0]; b = h[1]; c = h[2]; d = h[3]; e = h[4]; f = h[5]; g = h[6]; hh = h[7];
        for (int i = 0; i < 64; i++) begin
            t1 = hh + (ror(e, 6) ^ ror(e, 11) ^ ror(e, 25)) + ((e & f) ^ (~e & g)) + KT[i] + w[i];
            t2 = (ror(a, 2) ^ ror(a, 13) ^ ror(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
            hh = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
        end
        r[0] = h[0] + a; r[1] = h[1] + b; r[2] = h[2] + c; r[3] = h[3] + d;
        r[4] = h[4] + e; r[5] = h[5] + f; r[6] = h[6] + g; r[7] = h[7] + hh;
        return r;
    endfunction

    // Expected (nonce, H0) for every nonce of the job, from the current header.
    task automatic build_expect(input logic [31:0] base);
        st_t mid, d2, d3;
        blk_t b;
        logic [31:0] n;
        b   = header[0:15];
        mid = compress(IV_T, b);
        for (int k = 0; k < NUM_NONCES; k++) begin
            n     = base + 32'(k);
            b     = '0;
            b[0]  = header[16];
            b[1]  = header[17];
            b[2]  = header[18];
            b[3]  = n;
            b[4]  = 32'h80000000;
            b[15] = 32'd640;
            d2    = compress(mid, b);
            b     = '0;
            for (int j = 0; j < 8; j++) b[j] = d2[j];
            b[8]  = 32'h80000000;
            b[15] = 32'd256;
            d3    = compress(IV_T, b);
            exp_nonce[k] = n;
            exp_h0[k]    = d3[0];
        end
    endtask

    // Runs one job from the current negedge; returns at the negedge where done is seen.
    task automatic run_job(input string name, input logic [31:0] base, input bit rand_ready,
                           input int stall_idx, input bit hold, input bit check_lat);
        int c, k, stall_left, last_xfer;
        bit stalled_prev, stall_used;
        logic [31:0] prev_n, prev_h;
        for (int j = 0; j < 19; j++) header[j] = $urandom();
        nonce_base = base;
        build_expect(base);
        start = 1'b1;
        res_ready = 1'b1;
        c = 0; k = 0; stall_left = 0; last_xfer = 0;
        stalled_prev = 1'b0; stall_used = 1'b0; prev_n = '0; prev_h = '0;
        forever begin
            @(negedge clk);
            c++;
            if (!hold) start = 1'b0;
            if (c == 1) check({name, "_busy_rise"}, 32'(busy), 32'd1);
            if (stalled_prev) begin
                check({name, "_stall_valid"}, 32'(res_valid), 32'd1);
                check({name, "_stall_nonce"}, res_nonce, prev_n);
                check({name, "_stall_h0"}, res_h0, prev_h);
            end
            if (done) begin
                check({name, "_result_count"}, 32'(k), 32'(NUM_NONCES));
                check({name, "_busy_at_done"}, 32'(busy), 32'd0);
                check({name, "_done_after_last"}, 32'(c), 32'(last_xfer + 1));
                if (check_lat) check({name, "_latency"}, 32'(c), 32'(JOB_LAT));
                break;
            end
            if (c >= BUDGET) begin
                checks++;
                assert (done) else begin
                    errors++;
                    $error("FAIL %s_timeout done=%0b after %0d cycles, required 1", name, done, c);
                end
                break;
            end
            if (res_valid && k == stall_idx && !stall_used) begin
                stall_left = 20;
                stall_used = 1'b1;
            end
            if (stall_left > 0) begin
                res_ready = 1'b0;
                stall_left--;
            end else if (rand_ready) begin
                res_ready = 1'($urandom_range(0, 1));
            end else begin
                res_ready = 1'b1;
            end
            if (res_valid && res_ready) begin
                if (k < NUM_NONCES) begin
                    check($sformatf("%s_nonce%0d", name, k), res_nonce, exp_nonce[k]);
                    check($sformatf("%s_h0_%0d", name, k), res_h0, exp_h0[k]);
                end else begin
                    check({name, "_extra_result"}, 32'(k), 32'(NUM_NONCES - 1));
                end
                k++;
                last_xfer = c;
            end
            stalled_prev = res_valid && !res_ready;
            prev_n = res_nonce;
            prev_h = res_h0;
        end
    endtask

    initial begin
        st_t  abc_d;
        blk_t abc_b;

        abc_b     = '0;
        abc_b[0]  = 32'h61626380;
        abc_b[15] = 32'h00000018;
        abc_d     = compress(IV_T, abc_b);
        if (abc_d[0] !== 32'hba7816bf || abc_d[7] !== 32'hf20015ad)
            $fatal(1, "FAIL model_selftest observed=%h expected=ba7816bf", abc_d[0]);

        reset_n = 1'b0; start = 1'b0; res_ready = 1'b0;
        header = '0; nonce_base = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_valid", 32'(res_valid), 32'd0);
        check("rst_nonce", res_nonce, 32'd0);
        check("rst_h0", res_h0, 32'd0);
        reset_n = 1'b1;
        @(negedge clk);

        // Plain sweep from nonce 0 with the consumer always ready.
        run_job("base0", 32'd0, 1'b0, -1, 1'b0, 1'b1);
        @(negedge clk);
        check("base0_done_pulse", 32'(done), 32'd0);
        check("base0_idle_busy", 32'(busy), 32'd0);

        // Nonce wraps through 2^32 mid-sweep.
        run_job("wrap", 32'hFFFFFFF8, 1'b0, -1, 1'b0, 1'b1);
        @(negedge clk);

        // Random backpressure plus a 20-cycle stall on result 3.
        run_job("rand", $urandom(), 1'b1, 3, 1'b0, 1'b0);
        @(negedge clk);

        // start held through a job and through FIN; the next IDLE cycle accepts it.
        run_job("hold", 32'd100, 1'b0, -1, 1'b1, 1'b1);
        @(negedge clk);
        check("hold_fin_ignored_busy", 32'(busy), 32'd0);
        check("hold_done_pulse", 32'(done), 32'd0);
        run_job("restart", 32'd200, 1'b0, -1, 1'b0, 1'b1);

        // start only in the FIN cycle must not launch a job.
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("fin_start_busy", 32'(busy), 32'd0);
        @(negedge clk);
        check("fin_start_busy2", 32'(busy), 32'd0);
        check("fin_start_valid", 32'(res_valid), 32'd0);

        // Asynchronous reset during B3 rounds of the second batch.
        for (int j = 0; j < 19; j++) header[j] = $urandom();
        nonce_base = 32'h00001234;
        start = 1'b1;
        res_ready = 1'b1;
        for (int c = 1; c <= 280; c++) begin
            @(negedge clk);
            start = 1'b0;
        end
        check("mid_rst_busy_before", 32'(busy), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_done", 32'(done), 32'd0);
        check("mid_rst_valid", 32'(res_valid), 32'd0);
        check("mid_rst_nonce", res_nonce, 32'd0);
        check("mid_rst_h0", res_h0, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        run_job("post_rst", 32'hA5A50000, 1'b0, -1, 1'b0, 1'b1);
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
